// File: rtl/uart_tx_periph.sv
// APB slave UART transmitter: TX FIFO, programmable baud divider, 8N1 framing.
// Define UART_TX_PARITY_EN to insert an even-parity bit before STOP (8E1 framing).
module uart_tx_periph #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned BAUD_RST   = 867
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic [3:0]  PADDR,
  input  logic        PWRITE,
  input  logic        PENABLE,
  input  logic [31:0] PWDATA,
  input  logic        PSEL,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        tx,
  output logic        irq
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned BW = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_e;

  state_e        state_q, state_d;
  logic [BW-1:0] baud_cnt_q, baud_cnt_d;
  logic [BW-1:0] bauddiv_q, bauddiv_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          irq_q, irq_d;
  logic          pready_q, pready_d;
  logic [31:0]   prdata_q, prdata_d;
  logic          tx_en_q, tx_en_d;
  logic          irq_en_q, irq_en_d;
  logic          ovf_q, ovf_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [7:0]    mem_d [FIFO_DEPTH];
`ifdef UART_TX_PARITY_EN
  logic          parity_q, parity_d;
`endif

  logic          access, wr_acc, rd_acc;
  logic          push_req, push_ok, pop;
  logic          fifo_empty, fifo_full, busy, bit_done;
  logic [3:0]    count_sat;
  logic [31:0]   rdata;
  logic [7:0]    head;
  logic          unused_bits;

  assign access     = PSEL && PENABLE && !pready_q;
  assign wr_acc     = access && PWRITE;
  assign rd_acc     = access && !PWRITE;
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
  assign busy       = (state_q != ST_IDLE);
  assign bit_done   = (baud_cnt_q == '0);
  assign head       = mem_q[rd_ptr_q];
  assign push_req   = wr_acc && (PADDR[3:2] == 2'd2);
  // Push is judged on the pre-edge count, so a full FIFO drops even if a pop coincides.
  assign push_ok    = push_req && !fifo_full;
  assign pop        = (state_q == ST_IDLE) && tx_en_q && !fifo_empty;
  assign count_sat  = (32'(count_q) > 32'd15) ? 4'd15 : 4'(count_q);
  assign unused_bits = ^{PADDR[1:0], PWDATA[31:16]};

  assign PRDATA = prdata_q;
  assign PREADY = pready_q;
  assign tx     = tx_q;
  assign irq    = irq_q;

  // APB register file, read mux and FIFO bookkeeping.
  always_comb begin
    pready_d  = access;
    prdata_d  = prdata_q;
    tx_en_d   = tx_en_q;
    irq_en_d  = irq_en_q;
    bauddiv_d = bauddiv_q;
    ovf_d     = ovf_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    mem_d     = mem_q;
    rdata     = '0;

    unique case (PADDR[3:2])
      2'd0:    rdata = {30'd0, irq_en_q, tx_en_q};
      2'd1:    rdata = {24'd0, count_sat, ovf_q, busy, fifo_empty, fifo_full};
      2'd2:    rdata = '0;
      default: rdata = {16'd0, bauddiv_q};
    endcase

    if (rd_acc) begin
      prdata_d = rdata;
    end else if (wr_acc) begin
      prdata_d = '0;
    end

    if (wr_acc) begin
      unique case (PADDR[3:2])
        2'd0: begin
          tx_en_d  = PWDATA[0];
          irq_en_d = PWDATA[1];
        end
        2'd1: if (PWDATA[3]) ovf_d = 1'b0;
        2'd2: ;
        default: bauddiv_d = PWDATA[15:0];
      endcase
    end

    if (push_req && fifo_full) ovf_d = 1'b1;

    if (push_ok) begin
      mem_d[wr_ptr_q] = PWDATA[7:0];
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);

    unique case ({push_ok, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    irq_d = irq_en_q && fifo_empty && !busy;
  end

  // Transmit FSM; tx is registered from the current state, so the line lags the state by one cycle.
  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    tx_d       = 1'b1;
`ifdef UART_TX_PARITY_EN
    parity_d   = parity_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (pop) begin
          shift_d    = head;
          baud_cnt_d = bauddiv_q;
          bit_idx_d  = 3'd0;
          state_d    = ST_START;
`ifdef UART_TX_PARITY_EN
          parity_d   = ^head;
`endif
        end
      end
      ST_START: begin
        tx_d = 1'b0;
        if (bit_done) begin
          baud_cnt_d = bauddiv_q;
          state_d    = ST_DATA;
        end else begin
          baud_cnt_d = baud_cnt_q - BW'(1);
        end
      end
      ST_DATA: begin
        tx_d = shift_q[0];
        if (bit_done) begin
          baud_cnt_d = bauddiv_q;
          shift_d    = {1'b0, shift_q[7:1]};
          bit_idx_d  = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end
        end else begin
          baud_cnt_d = baud_cnt_q - BW'(1);
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        tx_d = parity_q;
        if (bit_done) begin
          baud_cnt_d = bauddiv_q;
          state_d    = ST_STOP;
        end else begin
          baud_cnt_d = baud_cnt_q - BW'(1);
        end
      end
`endif
      ST_STOP: begin
        tx_d = 1'b1;
        if (bit_done) begin
          state_d = ST_IDLE;
        end else begin
          baud_cnt_d = baud_cnt_q - BW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q    <= ST_IDLE;
      baud_cnt_q <= '0;
      bauddiv_q  <= BW'(BAUD_RST);
      bit_idx_q  <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      irq_q      <= 1'b0;
      pready_q   <= 1'b0;
      prdata_q   <= '0;
      tx_en_q    <= 1'b0;
      irq_en_q   <= 1'b0;
      ovf_q      <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
`ifdef UART_TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bauddiv_q  <= bauddiv_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      irq_q      <= irq_d;
      pready_q   <= pready_d;
      prdata_q   <= prdata_d;
      tx_en_q    <= tx_en_d;
      irq_en_q   <= irq_en_d;
      ovf_q      <= ovf_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
`ifdef UART_TX_PARITY_EN
      parity_q   <= parity_d;
`endif
    end
  end

  // FIFO storage needs no reset; pointers and count define its contents.
  always_ff @(posedge PCLK) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_uart_tx_periph.sv
// Directed bench for uart_tx_periph: register vector table plus framing, overflow, irq and reset sequences.
module tb_uart_tx_periph;

`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  logic        clk;
  logic        preset;
  logic [3:0]  paddr;
  logic        pwrite;
  logic        penable;
  logic [31:0] pwdata;
  logic        psel;
  logic [31:0] prdata;
  logic        pready;
  logic        tx;
  logic        irq;

  int n_checks;
  int n_fail;

  uart_tx_periph #(.FIFO_DEPTH(8), .BAUD_RST(867)) dut (
    .PCLK    (clk),
    .PRESET  (preset),
    .PADDR   (paddr),
    .PWRITE  (pwrite),
    .PENABLE (penable),
    .PWDATA  (pwdata),
    .PSEL    (psel),
    .PRDATA  (prdata),
    .PREADY  (pready),
    .tx      (tx),
    .irq     (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        wr;
    logic [3:0]  addr;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic apb_xfer(input logic wr, input logic [3:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata);
    logic got;
    @(negedge clk);
    psel    = 1'b1;
    penable = 1'b0;
    pwrite  = wr;
    paddr   = addr;
    pwdata  = wdata;
    @(negedge clk);
    penable = 1'b1;
    got     = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      if (pready) got = 1'b1;
    end
    rdata   = prdata;
    psel    = 1'b0;
    penable = 1'b0;
    pwrite  = 1'b0;
    if (!got) begin
      n_checks++;
      n_fail++;
      $display("FAIL apb_timeout addr 0x%0h: PREADY never rose, required 1", addr);
    end
  endtask

  task automatic apb_wr(input logic [3:0] addr, input logic [31:0] data);
    logic [31:0] dummy;
    apb_xfer(1'b1, addr, data, dummy);
  endtask

  task automatic apb_rd_check(input string name, input logic [3:0] addr, input logic [31:0] exp);
    logic [31:0] rd;
    apb_xfer(1'b0, addr, 32'h0, rd);
    check(name, rd, exp);
  endtask

  // Samples tx once per cycle across a whole frame, starting at the next falling clock edge.
  task automatic expect_frame(input logic [7:0] d, input int period, input string tag);
    logic [10:0] bits;
    bits    = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[i+1] = d[i];
`ifdef UART_TX_PARITY_EN
    bits[9]  = ^d;
    bits[10] = 1'b1;
`else
    bits[9]  = 1'b1;
`endif
    for (int b = 0; b < FRAME_BITS; b++) begin
      for (int c = 0; c < period; c++) begin
        @(negedge clk);
        check($sformatf("%s bit%0d cyc%0d tx", tag, b, c), 32'(tx), 32'(bits[b]));
      end
    end
  endtask

  initial begin
    int lows;
    n_checks = 0;
    n_fail   = 0;
    psel     = 1'b0;
    penable  = 1'b0;
    pwrite   = 1'b0;
    paddr    = '0;
    pwdata   = '0;
    preset   = 1'b1;

    vecs[0]  = '{1'b0, 4'h4, 32'h0,        32'h0000_0002};
    vecs[1]  = '{1'b0, 4'hC, 32'h0,        32'd867};
    vecs[2]  = '{1'b0, 4'h0, 32'h0,        32'h0};
    vecs[3]  = '{1'b0, 4'h8, 32'h0,        32'h0};
    vecs[4]  = '{1'b1, 4'hC, 32'hABCD0005, 32'h0};
    vecs[5]  = '{1'b0, 4'hC, 32'h0,        32'h0000_0005};
    vecs[6]  = '{1'b1, 4'h0, 32'hFFFFFFFC, 32'h0};
    vecs[7]  = '{1'b0, 4'h0, 32'h0,        32'h0};
    vecs[8]  = '{1'b1, 4'h0, 32'h0000_0002, 32'h0};
    vecs[9]  = '{1'b0, 4'h0, 32'h0,        32'h0000_0002};
    vecs[10] = '{1'b1, 4'h0, 32'h0,        32'h0};
    vecs[11] = '{1'b0, 4'h4, 32'h0,        32'h0000_0002};
    vecs[12] = '{1'b1, 4'hC, 32'h0000_0003, 32'h0};
    vecs[13] = '{1'b0, 4'hC, 32'h0,        32'h0000_0003};

    repeat (3) @(negedge clk);
    check("reset tx", 32'(tx), 32'h1);
    check("reset PREADY", 32'(pready), 32'h0);
    check("reset PRDATA", prdata, 32'h0);
    check("reset irq", 32'(irq), 32'h0);
    preset = 1'b0;

    for (int i = 0; i < 14; i++) begin
      logic [31:0] rd;
      apb_xfer(vecs[i].wr, vecs[i].addr, vecs[i].data, rd);
      if (!vecs[i].wr) check($sformatf("vec%0d rd 0x%0h", i, vecs[i].addr), rd, vecs[i].exp);
    end

    lows = 0;
    repeat (20) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    check("idle tx low cycles", 32'(lows), 32'h0);

    // Single frame of 0x55 at 4 cycles per bit.
    apb_wr(4'h0, 32'h1);
    apb_wr(4'h8, 32'h55);
    @(negedge clk);
    check("pre-start tx", 32'(tx), 32'h1);
    expect_frame(8'h55, 4, "f55");
    apb_rd_check("status after frame", 4'h4, 32'h0000_0002);

    // Overflow and W1C with transmitter disabled.
    apb_wr(4'h0, 32'h0);
    for (int i = 0; i < 9; i++) apb_wr(4'h8, 32'(i + 16));
    apb_rd_check("status overflow", 4'h4, 32'h0000_0089);
    apb_wr(4'h4, 32'h7);
    apb_rd_check("status w1c other bits", 4'h4, 32'h0000_0089);
    apb_wr(4'h4, 32'h8);
    apb_rd_check("status w1c clear", 4'h4, 32'h0000_0081);
    check("tx idle while disabled", 32'(tx), 32'h1);

    @(negedge clk);
    preset = 1'b1;
    @(negedge clk);
    preset = 1'b0;
    apb_rd_check("status after flush", 4'h4, 32'h0000_0002);
    apb_rd_check("bauddiv after reset", 4'hC, 32'd867);

    // Back-to-back frames at one cycle per bit.
    apb_wr(4'hC, 32'h0);
    apb_wr(4'h8, 32'hA5);
    apb_wr(4'h8, 32'h3C);
    apb_wr(4'h0, 32'h1);
    @(negedge clk);
    check("b2b pre-start tx", 32'(tx), 32'h1);
    expect_frame(8'hA5, 1, "fA5");
    @(negedge clk);
    check("b2b idle gap tx", 32'(tx), 32'h1);
    expect_frame(8'h3C, 1, "f3C");
    @(negedge clk);
    check("b2b after tx", 32'(tx), 32'h1);

    // irq timing around one frame at 2 cycles per bit.
    apb_wr(4'hC, 32'h1);
    apb_wr(4'h0, 32'h3);
    @(negedge clk);
    check("irq idle empty", 32'(irq), 32'h1);
    apb_wr(4'h8, 32'h81);
    for (int i = 0; i < 2 * FRAME_BITS + 1; i++) begin
      @(negedge clk);
      check($sformatf("irq low cyc%0d", i), 32'(irq), 32'h0);
    end
    @(negedge clk);
    check("irq rise after frame", 32'(irq), 32'h1);

    // Reset during DATA with bytes still queued.
    apb_wr(4'hC, 32'h3);
    apb_wr(4'h0, 32'h0);
    apb_wr(4'h8, 32'h00);
    apb_wr(4'h8, 32'h00);
    apb_wr(4'h8, 32'h00);
    apb_wr(4'h0, 32'h1);
    repeat (8) @(negedge clk);
    check("mid-data tx low", 32'(tx), 32'h0);
    preset = 1'b1;
    @(negedge clk);
    check("reset abort tx", 32'(tx), 32'h1);
    check("reset abort irq", 32'(irq), 32'h0);
    preset = 1'b0;
    apb_rd_check("status after abort", 4'h4, 32'h0000_0002);
    lows = 0;
    repeat (60) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    check("no frame after abort", 32'(lows), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
